// File: rtl/dff_sig_pkg.sv
// Shared constants and types for the DFF-array signature capture block.
// Holds MISR tap positions, FSM state encoding and the default seed.
package dff_sig_pkg;

  localparam int unsigned TAP_A = 47;
  localparam int unsigned TAP_B = 46;
  localparam int unsigned TAP_C = 20;
  localparam int unsigned TAP_D = 19;

  localparam logic [47:0] SIG_SEED_DEFAULT =
    48'h0000_0000_0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sig_state_t;

endpackage

// File: rtl/dff_sig_misr.sv
// One combinational MISR step: shift in the tap feedback, then fold
// in the sampled data word.
module dff_sig_misr
  import dff_sig_pkg::*;
#(
  parameter int unsigned WIDTH = 48
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] s_next_o
);

  logic fb;

  // Feedback from the fixed taps, shifted into bit 0.
  always_comb begin
    fb = s_i[TAP_A] ^ s_i[TAP_B] ^ s_i[TAP_C] ^ s_i[TAP_D];
    s_next_o = {s_i[WIDTH-2:0], fb} ^ d_i;
  end

endmodule

// File: rtl/dff_signature_capture.sv
// Compresses a CYCLES-long window of the DFF array q bus into a MISR
// signature. Optional golden compare: define DFF_SIG_CHECK_EN.
module dff_signature_capture
  import dff_sig_pkg::*;
#(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned CYCLES = 256,
  parameter logic [WIDTH-1:0] SEED =
    WIDTH'(SIG_SEED_DEFAULT)
`ifdef DFF_SIG_CHECK_EN
  ,
  parameter logic [WIDTH-1:0] EXPECT = '0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig
`ifdef DFF_SIG_CHECK_EN
  ,
  output logic             pass,
  output logic             fail
`endif
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  sig_state_t state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] q_r_q;
  logic [WIDTH-1:0] s_next;
  logic [CW-1:0] cnt_q, cnt_d;

  dff_sig_misr #(
    .WIDTH(WIDTH)
  ) u_misr (
    .s_i     (sig_q),
    .d_i     (q_r_q),
    .s_next_o(s_next)
  );

  // Register the array outputs every cycle; the MISR only sees q_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_r_q <= '0;
    else     q_r_q <= q_in;
  end

  // Run sequencing: start loads the seed, RUN absorbs CYCLES words.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sig_d = s_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, signature and sample counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sig  = sig_q;

`ifdef DFF_SIG_CHECK_EN
  logic pass_q, fail_q;
  logic last_step;
  logic accept;

  assign last_step = (state_q == S_RUN) && (cnt_q == LAST);
  assign accept    = start && (state_q != S_RUN);

  // Verdict latched with the final step, cleared by a new run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (last_step) begin
      pass_q <= (s_next == EXPECT);
      fail_q <= (s_next != EXPECT);
    end else if (accept) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_dff_signature_capture.sv
// Directed bench for dff_signature_capture: short hand-checked runs,
// LFSR/MISR model runs, reset abort, ignored start and check mode.
module tb_dff_signature_capture;

  localparam logic [47:0] SEED_D = 48'h1;

  typedef struct {
    logic [47:0] q;
    logic [47:0] exp1;
    logic [47:0] exp2;
  } vec_t;

  vec_t tbl [6];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [47:0] q_in = '0;
  logic st1 = 0, st2 = 0, st48 = 0, st256 = 0;
  logic b1, d1, b2, d2, b48, d48, b256, d256;
  logic [47:0] s1, s2, s48, s256;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef DFF_SIG_CHECK_EN
  logic [3:0] pd, fd;
  logic stc = 0;
  logic bp, dp, bf, df, pp, fp, pf, ff;
  logic [47:0] sp, sf;

  dff_signature_capture #(
    .CYCLES(2), .SEED(48'h0), .EXPECT(48'h3)
  ) u_cp (
    .clk(clk), .rst(rst), .start(stc), .q_in(q_in),
    .busy(bp), .done(dp), .sig(sp),
    .pass(pp), .fail(fp)
  );

  dff_signature_capture #(
    .CYCLES(2), .SEED(48'h0), .EXPECT(48'h2)
  ) u_cf (
    .clk(clk), .rst(rst), .start(stc), .q_in(q_in),
    .busy(bf), .done(df), .sig(sf),
    .pass(pf), .fail(ff)
  );
`endif

  dff_signature_capture #(
    .CYCLES(1), .SEED(48'h0)
  ) u1 (
    .clk(clk), .rst(rst), .start(st1), .q_in(q_in),
    .busy(b1), .done(d1), .sig(s1)
`ifdef DFF_SIG_CHECK_EN
    , .pass(pd[0]), .fail(fd[0])
`endif
  );

  dff_signature_capture #(
    .CYCLES(2), .SEED(48'h0)
  ) u2 (
    .clk(clk), .rst(rst), .start(st2), .q_in(q_in),
    .busy(b2), .done(d2), .sig(s2)
`ifdef DFF_SIG_CHECK_EN
    , .pass(pd[1]), .fail(fd[1])
`endif
  );

  dff_signature_capture #(
    .CYCLES(48)
  ) u48 (
    .clk(clk), .rst(rst), .start(st48), .q_in(q_in),
    .busy(b48), .done(d48), .sig(s48)
`ifdef DFF_SIG_CHECK_EN
    , .pass(pd[2]), .fail(fd[2])
`endif
  );

  dff_signature_capture u256 (
    .clk(clk), .rst(rst), .start(st256), .q_in(q_in),
    .busy(b256), .done(d256), .sig(s256)
`ifdef DFF_SIG_CHECK_EN
    , .pass(pd[3]), .fail(fd[3])
`endif
  );

  function automatic logic [47:0] step(
    input logic [47:0] s,
    input logic [47:0] d
  );
    logic fb;
    fb = s[47] ^ s[46] ^ s[20] ^ s[19];
    return {s[46:0], fb} ^ d;
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom()), $urandom()};
  endfunction

  task automatic chk(
    input string nm,
    input logic [47:0] act,
    input logic [47:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run48(input bit rnd, input bit poke);
    logic [47:0] ms, cur, qprev;
    cur = rnd ? rnd48() : 48'h0;
    q_in = cur;
    st48 = 1;
    tick();
    st48 = 0;
    ms = SEED_D;
    chk("r48 busy", 48'(b48), 48'h1);
    chk("r48 seed", s48, SEED_D);
    for (int i = 0; i < 48; i++) begin
      qprev = cur;
      if (rnd) cur = rnd48();
      q_in = cur;
      st48 = (poke && i == 10);
      tick();
      ms = step(ms, qprev);
      if (i == 46)
        chk("r48 early done", 48'(d48), 48'h0);
    end
    st48 = 0;
    chk("r48 done", 48'(d48), 48'h1);
    chk("r48 busy off", 48'(b48), 48'h0);
    chk("r48 sig", s48, ms);
  endtask

  initial begin
    tbl[0] = '{48'h1, 48'h1, 48'h3};
    tbl[1] = '{48'h2, 48'h2, 48'h6};
    tbl[2] = '{48'h8000_0000_0000,
               48'h8000_0000_0000,
               48'h8000_0000_0001};
    tbl[3] = '{48'h0000_0010_0000,
               48'h0000_0010_0000,
               48'h0000_0030_0001};
    tbl[4] = '{48'hC000_0000_0000,
               48'hC000_0000_0000,
               48'h4000_0000_0000};
    tbl[5] = '{48'h0, 48'h0, 48'h0};

    tick();
    tick();
    chk("rst busy", 48'(b256), 48'h0);
    chk("rst done", 48'(d256), 48'h0);
    chk("rst sig256", s256, SEED_D);
    chk("rst sig1", s1, 48'h0);
    chk("rst done1", 48'(d1), 48'h0);
    rst = 0;
    tick();

    for (int i = 0; i < 6; i++) begin
      q_in = tbl[i].q;
      st1 = 1;
      st2 = 1;
      tick();
      st1 = 0;
      st2 = 0;
      chk("v busy2 k", 48'(b2), 48'h1);
      chk("v sig2 k", s2, 48'h0);
      chk("v busy1 k", 48'(b1), 48'h1);
      tick();
      chk("v sig2 k1", s2, tbl[i].exp1);
      chk("v busy2 k1", 48'(b2), 48'h1);
      chk("v done2 k1", 48'(d2), 48'h0);
      chk("v done1 k1", 48'(d1), 48'h1);
      chk("v sig1 k1", s1, tbl[i].exp1);
      tick();
      chk("v sig2 k2", s2, tbl[i].exp2);
      chk("v done2 k2", 48'(d2), 48'h1);
      chk("v busy2 k2", 48'(b2), 48'h0);
      chk("v sig1 hold", s1, tbl[i].exp1);
    end

    st1 = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held busy", 48'(b1), 48'(i % 2 == 0));
      chk("held done", 48'(d1), 48'(i % 2 == 1));
    end
    st1 = 0;
    tick();

    run48(0, 0);
    run48(1, 0);
    run48(0, 1);
    run48(1, 1);

    q_in = '0;
    st256 = 1;
    tick();
    st256 = 0;
    repeat (100) tick();
    chk("abort busy pre", 48'(b256), 48'h1);
    rst = 1;
    #1;
    chk("abort busy", 48'(b256), 48'h0);
    chk("abort done", 48'(d256), 48'h0);
    chk("abort sig", s256, SEED_D);
    tick();
    rst = 0;
    tick();

    begin
      logic [47:0] ms;
      ms = SEED_D;
      st256 = 1;
      tick();
      st256 = 0;
      for (int i = 0; i < 256; i++) begin
        tick();
        ms = step(ms, 48'h0);
        if (i == 254)
          chk("r256 early done", 48'(d256), 48'h0);
      end
      chk("r256 done", 48'(d256), 48'h1);
      chk("r256 sig", s256, ms);
    end

`ifdef DFF_SIG_CHECK_EN
    q_in = 48'h1;
    stc = 1;
    tick();
    stc = 0;
    tick();
    tick();
    chk("chk pass", 48'(pp), 48'h1);
    chk("chk nofail", 48'(fp), 48'h0);
    chk("chk nopass", 48'(pf), 48'h0);
    chk("chk fail", 48'(ff), 48'h1);
    stc = 1;
    tick();
    stc = 0;
    chk("clr pass", 48'(pp), 48'h0);
    chk("clr fail", 48'(ff), 48'h0);
    tick();
    tick();
    chk("again pass", 48'(pp), 48'h1);
    chk("again fail", 48'(ff), 48'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
